// File: rtl/phase_sequencer_pkg.sv
// rtl/phase_sequencer_pkg.sv - shared phase and opcode encodings for the sequencer and controller
package phase_sequencer_pkg;

    typedef enum logic [2:0] {
        PH_INST_ADDR    = 3'b000,
        PH_INST_READ    = 3'b001,
        PH_DECODE       = 3'b010,
        PH_OPERAND_ADDR = 3'b011,
        PH_OPERAND_READ = 3'b100,
        PH_EXECUTE      = 3'b101,
        PH_WRITEBACK    = 3'b110,
        PH_STORE        = 3'b111
    } phase_t;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDA = 4'h1,
        OP_ADD = 4'h2,
        OP_SUB = 4'h3,
        OP_STA = 4'h4,
        OP_JMP = 4'h5,
        OP_HLT = 4'hF
    } opcode_t;

    // The controller decodes HLT in time to raise halt during this phase.
    localparam phase_t PH_HALT_CHECK = PH_OPERAND_READ;

    function automatic phase_t next_phase(input phase_t p);
        return phase_t'(p + 3'd1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up-counter with enable that sticks at all-ones
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (en && (q != {W{1'b1}})) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/phase_sequencer.sv
// rtl/phase_sequencer.sv - instruction phase FSM with run/step/halt control and retired-instruction count
module phase_sequencer
    import phase_sequencer_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             step_req,
    input  logic             halt,
    output logic [2:0]       phase,
    output logic             step_ack,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_STEP,
        S_HALTED
    } state_t;

    state_t state;
    phase_t ph;
    logic   active;
    logic   wrap;
    logic   halt_hit;

    assign phase = ph;

    always_comb begin
        active   = (state == S_RUN) || (state == S_STEP);
        wrap     = active && (ph == PH_STORE);
        halt_hit = active && halt && (ph == PH_HALT_CHECK);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            ph       <= PH_INST_ADDR;
            step_ack <= 1'b0;
            halted   <= 1'b0;
        end else begin
            step_ack <= 1'b0;
            case (state)
                S_IDLE: begin
                    ph <= PH_INST_ADDR;
                    if (run) begin
                        state <= S_RUN;
                    end else if (step_req) begin
                        state <= S_STEP;
                    end
                end
                S_RUN, S_STEP: begin
                    if (halt_hit) begin
                        // Phase freezes at the halt-check phase; HLT is never retired.
                        state    <= S_HALTED;
                        halted   <= 1'b1;
                        step_ack <= (state == S_STEP);
                    end else begin
                        ph <= next_phase(ph);
                        if (wrap) begin
                            state    <= run ? S_RUN : S_IDLE;
                            step_ack <= (state == S_STEP);
                        end
                    end
                end
                S_HALTED: begin
                    halted <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_instr_count (
        .clk(clk),
        .rst(rst),
        .en (wrap),
        .q  (instr_count)
    );

endmodule

// File: tb/tb_phase_sequencer.sv
// tb/tb_phase_sequencer.sv - self-checking bench: vector table, corner sequences, random vs reference model
module tb_phase_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic        step_req;
    logic        halt;
    logic [2:0]  phase, phase4;
    logic        step_ack, ack4;
    logic        halted, halted4;
    logic [15:0] cnt;
    logic [3:0]  cnt4;

    always #5 clk = ~clk;

    phase_sequencer #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .run(run), .step_req(step_req), .halt(halt),
        .phase(phase), .step_ack(step_ack), .halted(halted), .instr_count(cnt)
    );

    phase_sequencer #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .run(run), .step_req(step_req), .halt(halt),
        .phase(phase4), .step_ack(ack4), .halted(halted4), .instr_count(cnt4)
    );

    int compared = 0;
    int mismatched = 0;

    // Reference model: position within the instruction, whether an
    // instruction is in flight, whether it was started by a single step.
    int m_pos;
    int m_count;
    bit m_busy;
    bit m_single;
    bit m_stopped;
    bit m_ack;

    typedef struct {
        bit       r;
        bit       s;
        bit       h;
        int       ph;
        int       ack;
        int       hlt;
        int       cnt;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        m_pos = 0; m_count = 0; m_busy = 0; m_single = 0; m_stopped = 0; m_ack = 0;
    endtask

    task automatic model_step(input bit r, input bit s, input bit h);
        m_ack = 0;
        if (m_stopped) begin
            // frozen until reset
        end else if (!m_busy) begin
            if (r) begin
                m_busy = 1; m_single = 0;
            end else if (s) begin
                m_busy = 1; m_single = 1;
            end
        end else if (m_pos == 4 && h) begin
            m_stopped = 1; m_busy = 0; m_ack = m_single;
        end else if (m_pos == 7) begin
            m_pos = 0;
            m_count++;
            m_ack = m_single;
            m_single = 0;
            m_busy = r;
        end else begin
            m_pos++;
        end
    endtask

    task automatic check_all();
        chk("phase", phase, m_pos);
        chk("step_ack", step_ack, m_ack);
        chk("halted", halted, m_stopped);
        chk("instr_count", cnt, sat(m_count, 65535));
        chk("phase_w4", phase4, m_pos);
        chk("step_ack_w4", ack4, m_ack);
        chk("halted_w4", halted4, m_stopped);
        chk("instr_count_w4", cnt4, sat(m_count, 15));
    endtask

    task automatic cyc(input bit r, input bit s, input bit h, input bit rs);
        rst = rs; run = r; step_req = s; halt = h;
        @(posedge clk);
        #1;
        if (rs) model_reset();
        else model_step(r, s, h);
        check_all();
    endtask

    task automatic do_reset();
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        rst = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1; run = 1'b0; step_req = 1'b0; halt = 1'b0;
        #1;
        model_reset();
        check_all();
        do_reset();

        // Single step with an ignored mid-instruction step_req and off-phase halt
        tbl[0]  = '{0, 1, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 0, 0, 1, 0, 0, 0};
        tbl[2]  = '{0, 1, 0, 2, 0, 0, 0};
        tbl[3]  = '{0, 0, 0, 3, 0, 0, 0};
        tbl[4]  = '{0, 0, 1, 4, 0, 0, 0};
        tbl[5]  = '{0, 0, 0, 5, 0, 0, 0};
        tbl[6]  = '{0, 0, 0, 6, 0, 0, 0};
        tbl[7]  = '{0, 0, 0, 7, 0, 0, 0};
        tbl[8]  = '{0, 0, 0, 0, 1, 0, 1};
        tbl[9]  = '{0, 0, 0, 0, 0, 0, 1};
        tbl[10] = '{1, 0, 0, 0, 0, 0, 1};
        tbl[11] = '{1, 0, 0, 1, 0, 0, 1};
        for (int i = 0; i < 12; i++) begin
            cyc(tbl[i].r, tbl[i].s, tbl[i].h, 0);
            chk($sformatf("tbl%0d_phase", i), phase, tbl[i].ph);
            chk($sformatf("tbl%0d_ack", i), step_ack, tbl[i].ack);
            chk($sformatf("tbl%0d_halted", i), halted, tbl[i].hlt);
            chk($sformatf("tbl%0d_count", i), cnt, tbl[i].cnt);
        end

        // run dropped at phase 010 finishes the instruction then idles
        n = 0;
        while (m_pos != 2 && n < 20) begin cyc(1, 0, 0, 0); n++; end
        chk("reach_phase2", m_pos, 2);
        n = 0;
        while (m_busy && n < 20) begin cyc(0, 0, 0, 0); n++; end
        chk("drop_run_phase", phase, 0);
        chk("drop_run_count", cnt, 2);
        cyc(0, 0, 0, 0);
        chk("drop_run_idle", phase, 0);

        // three full instructions from IDLE
        do_reset();
        for (int i = 0; i < 25; i++) cyc(1, 0, 0, 0);
        chk("run3_count", cnt, 3);
        chk("run3_phase", phase, 0);
        chk("run3_halted", halted, 0);

        // halt at phase 100 of the 2nd instruction, then ignore everything
        do_reset();
        n = 0;
        while (!(m_busy && m_pos == 4 && m_count == 1) && n < 40) begin cyc(1, 0, 0, 0); n++; end
        chk("reach_halt_point", m_count, 1);
        cyc(1, 0, 1, 0);
        for (int i = 0; i < 22; i++) cyc(1'($urandom), 1'($urandom), 1'($urandom), 0);
        chk("halt_phase", phase, 4);
        chk("halt_flag", halted, 1);
        chk("halt_count", cnt, 1);
        rst = 1'b1;
        #1;
        model_reset();
        chk("halt_rst_phase", phase, 0);
        chk("halt_rst_flag", halted, 0);
        chk("halt_rst_count", cnt, 0);
        do_reset();

        // halt during a step acknowledges the step
        cyc(0, 1, 0, 0);
        n = 0;
        while (m_pos != 4 && n < 20) begin cyc(0, 0, 0, 0); n++; end
        cyc(0, 0, 1, 0);
        chk("step_halt_ack", step_ack, 1);
        cyc(0, 0, 0, 0);
        chk("step_halt_ack_once", step_ack, 0);
        do_reset();

        // halt at every phase except 100 is ignored
        for (int i = 0; i < 40; i++) cyc(1, 0, (m_pos != 4), 0);
        chk("offphase_halt", halted, 0);
        chk("offphase_count", cnt, 4);

        // saturation of the 4-bit counter, then reset at phase 101
        do_reset();
        for (int i = 0; i < 17 * 8 + 1; i++) cyc(1, 0, 0, 0);
        chk("sat_w4", cnt4, 15);
        chk("nosat_w16", cnt, 17);
        n = 0;
        while (m_pos != 5 && n < 20) begin cyc(1, 0, 0, 0); n++; end
        rst = 1'b1;
        #1;
        model_reset();
        chk("midrst_phase", phase, 0);
        chk("midrst_count", cnt, 0);
        chk("midrst_count_w4", cnt4, 0);
        do_reset();

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom % 8) != 0, ($urandom % 4) == 0, ($urandom % 3) == 0,
                ($urandom % 200) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/phase_sequencer.md
PHASE_SEQUENCER -- requirements
Module: phase_sequencer

Interface
REQ-001 Parameter: CNT_W, default 16, width of the retired-instruction counter.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-003 Port: clk  input  1  system clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: run  input  1  level; 1 = free-run instructions, 0 = stop at the next instruction boundary.
REQ-006 Port: step_req  input  1  request to execute exactly one instruction; sampled only in IDLE.
REQ-007 Port: halt  input  1  halt indication from the controller; qualified internally.
REQ-008 Port: phase  output  3  current instruction phase (000 INST_ADDR ... 111 STORE), fed to the controller.
REQ-009 Port: step_ack  output  1  one-cycle pulse when a stepped instruction finishes or halts.
REQ-010 Port: halted  output  1  high while in HALTED.
REQ-011 Port: instr_count  output  CNT_W  number of retired instructions, saturating.

Function
REQ-012 The block SHALL be an FSM with the states IDLE, RUN, STEP and HALTED; all outputs SHALL be registered.
REQ-013 In IDLE, phase SHALL hold 000; run=1 SHALL move to RUN; otherwise step_req=1 SHALL move to STEP; run has priority over step_req.
REQ-014 In RUN and STEP, phase SHALL increment by 1 per clock and wrap from 111 to 000.
REQ-015 Each 111->000 wrap SHALL retire one instruction: instr_count increments by 1 and saturates at all-ones.
REQ-016 In RUN, a wrap with run=0 SHALL enter IDLE with phase=000; with run=1, RUN continues.
REQ-017 In STEP, the first wrap SHALL enter RUN if run=1 and IDLE otherwise, and SHALL pulse step_ack for exactly the cycle after the wrap edge.
REQ-018 step_req asserted outside IDLE SHALL be ignored (no queuing); run changes mid-instruction SHALL take effect only at the wrap.
REQ-019 halt SHALL be honoured only when sampled with phase=100; at other phases it SHALL be ignored.
REQ-020 A qualified halt SHALL enter HALTED on the same edge, freeze phase at 100, set halted=1, and leave instr_count unchanged (the HLT instruction is not counted).
REQ-021 A qualified halt in STEP SHALL also pulse step_ack once so the handshake never hangs.
REQ-022 HALTED SHALL be left only by reset; run, step_req and halt SHALL be ignored there.
REQ-023 Latency: from run rising in IDLE, phase=001 SHALL appear 2 edges later (edge 1 to RUN at phase 000, edge 2 to 001); one instruction SHALL take 8 clocks.

Reset
REQ-024 While rst=1, asynchronously: state=IDLE, phase=000, step_ack=0, halted=0, instr_count=0.
REQ-025 Reset asserted mid-instruction or in HALTED SHALL abort without retiring the instruction; after release the block SHALL start at IDLE.

Structure
REQ-026 The phase encodings (000..111) and opcode encodings SHALL live in one shared definitions include used by both the controller and this block.
REQ-027 FSM state encodings SHALL be local to this block.
REQ-028 One sub-module SHALL be used: sat_counter (width CNT_W, enable, async reset) for instr_count.

Verification
REQ-029 Reset release, then run=1 with halt=0 for 24 clocks -> phase steps 000..111 three times; instr_count=3; halted=0.
REQ-030 In IDLE, step_req=1 for 1 clock -> exactly 8 phase steps, then step_ack=1 for one cycle, phase=000, IDLE, instr_count=1; a second step_req mid-instruction is ignored.
REQ-031 RUN with halt=1 driven at phase=100 of the 2nd instruction -> halted=1, phase stuck at 100 for 20+ clocks, instr_count=1; run toggling has no effect; rst clears everything.
REQ-032 halt=1 held at every phase except 100 -> no halt; run continues normally.
REQ-033 run dropped at phase=010 -> instruction completes, IDLE at phase=000, instr_count incremented once.
REQ-034 With CNT_W=4, run for 17 instructions -> instr_count saturates at 15; rst asserted at phase=101 -> immediate phase=000 and instr_count=0.
